// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity modes and field selectors
// used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    localparam logic [1:0] SEL_START  = 2'd0;
    localparam logic [1:0] SEL_DATA   = 2'd1;
    localparam logic [1:0] SEL_PARITY = 2'd2;
    localparam logic [1:0] SEL_STOP   = 2'd3;

    // Mode 2'b11 is reserved and behaves as no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Parity bit generator: XOR of all data bits, inverted for odd parity.
module uart_parity_gen #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              odd_i,
    output logic              parity_o
);

    assign parity_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: one-word holding register feeding a baud-tick paced
// frame FSM (start, LSB-first data, optional parity, one or two stop bits).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [1:0]        frame_sel
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              tx_out_q, tx_out_d;
    logic [1:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load;
    logic              par_calc;

    // Parity is computed from the holding register so it is ready at load time.
    uart_parity_gen #(.DATA_W(DATA_W)) u_parity (
        .data_i   (hold_data_q),
        .odd_i    (parity_mode == PARITY_ODD),
        .parity_o (par_calc)
    );

    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        stop_cnt_d   = stop_cnt_q;
        done_d       = 1'b0;
        load         = 1'b0;

        // Accept only into an empty holding register; load only from a full one.
        if (tx_valid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_data_d  = tx_data;
        end

        if (baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_valid_q) load = 1'b1;
                end
                ST_START: begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
                ST_DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d    = ST_STOP;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
                ST_STOP: begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (hold_valid_q) load = 1'b1;
                        else              state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Frame configuration is sampled here so mid-frame changes wait a frame.
        if (load) begin
            state_d      = ST_START;
            shift_d      = hold_data_q;
            hold_valid_d = 1'b0;
            par_en_d     = parity_enabled(parity_mode);
            par_bit_d    = par_calc;
            stop2_d      = stop2;
        end

        tx_out_d = 1'b1;
        sel_d    = SEL_STOP;
        case (state_d)
            ST_START: begin
                tx_out_d = 1'b0;
                sel_d    = SEL_START;
            end
            ST_DATA: begin
                tx_out_d = shift_d[0];
                sel_d    = SEL_DATA;
            end
            ST_PARITY: begin
                tx_out_d = par_bit_d;
                sel_d    = SEL_PARITY;
            end
            default: begin
                tx_out_d = 1'b1;
                sel_d    = SEL_STOP;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop2_q      <= 1'b0;
            stop_cnt_q   <= 1'b0;
            tx_out_q     <= 1'b1;
            sel_q        <= SEL_STOP;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            stop2_q      <= stop2_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_out_q     <= tx_out_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tx_ready  = !hold_valid_q;
    assign tx_out    = tx_out_q;
    assign frame_sel = sel_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: constant frame table, corner-case
// sequences and randomized bursts checked against a string-based frame model.
module tb_uart_tx_serializer;

    typedef struct {
        int         w;
        logic [8:0] data;
        logic [1:0] pm;
        logic       s2;
        string      line;
        string      sel;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic       tick_en;

    logic [7:0] data8;
    logic       valid8, ready8, s2_8, out8, busy8, done8;
    logic [1:0] pm8, sel8;
    logic [6:0] data7;
    logic       valid7, ready7, s2_7, out7, busy7, done7;
    logic [1:0] pm7, sel7;

    int         total = 0;
    int         bad = 0;
    int         dut_sel = 8;
    logic [2:0] exp_q[$];
    vec_t       vecs[8];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .tx_data(data8), .tx_valid(valid8), .tx_ready(ready8),
        .parity_mode(pm8), .stop2(s2_8), .tx_out(out8),
        .tx_busy(busy8), .tx_done(done8), .frame_sel(sel8)
    );

    uart_tx_serializer #(.DATA_W(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .tx_data(data7), .tx_valid(valid7), .tx_ready(ready7),
        .parity_mode(pm7), .stop2(s2_7), .tx_out(out7),
        .tx_busy(busy7), .tx_done(done7), .frame_sel(sel7)
    );

    // Baud ticks at random spacing while enabled, driven away from the active edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick = tick_en && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // {done, busy, frame_sel, tx_out} of the DUT selected by dut_sel
    function automatic logic [4:0] obs();
        if (dut_sel == 7) return {done7, busy7, sel7, out7};
        return {done8, busy8, sel8, out8};
    endfunction

    function automatic logic rdy(input int which);
        return (which == 7) ? ready7 : ready8;
    endfunction

    function automatic vec_t mk(input int w, input logic [8:0] d, input logic [1:0] pm,
                                input logic s2, input string line, input string sel);
        vec_t v;
        v.w = w; v.data = d; v.pm = pm; v.s2 = s2; v.line = line; v.sel = sel;
        return v;
    endfunction

    // Reference frame: one character per tick period, line level and field code.
    function automatic void build_frame(input logic [8:0] d, input int w, input logic [1:0] pm,
                                        input logic s2, output string line, output string sel);
        logic p;
        p = 1'b0;
        line = "0";
        sel = "0";
        for (int i = 0; i < w; i++) begin
            line = {line, d[i] ? "1" : "0"};
            sel = {sel, "1"};
            p = p ^ d[i];
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            line = {line, ((pm == 2'b10) ? !p : p) ? "1" : "0"};
            sel = {sel, "2"};
        end
        line = {line, "1"};
        sel = {sel, "3"};
        if (s2) begin
            line = {line, "1"};
            sel = {sel, "3"};
        end
    endfunction

    task automatic wait_tick();
        int g;
        g = 0;
        do begin
            @(posedge clk);
            g++;
        end while (!baud_tick && g < 200);
        if (!baud_tick) fail_now("wait_tick timeout: no baud tick within 200 cycles");
        #1;
    endtask

    task automatic set_cfg(input int which, input logic [1:0] pm, input logic s2);
        if (which == 7) begin pm7 = pm; s2_7 = s2; end
        else begin pm8 = pm; s2_8 = s2; end
    endtask

    task automatic send(input int which, input logic [8:0] d);
        int g;
        @(negedge clk);
        if (which == 7) begin data7 = d[6:0]; valid7 = 1'b1; end
        else begin data8 = d[7:0]; valid8 = 1'b1; end
        g = 0;
        while (!rdy(which) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!rdy(which)) fail_now("send timeout: tx_ready stayed 0, expected 1");
        @(posedge clk);
        @(negedge clk);
        valid7 = 1'b0;
        valid8 = 1'b0;
    endtask

    // first: 0 = wait for the load tick, 1 = already at start after a done edge,
    // 2 = already at start with no done pulse. chain_out: next frame follows directly.
    task automatic check_frame(input string line, input string sel, input int first,
                               input bit chain_out, input string name);
        logic [7:0] lc, sc;
        logic       exp_done;
        for (int i = 0; i < line.len(); i++) begin
            if (!(i == 0 && first != 0)) wait_tick();
            lc = line[i];
            sc = sel[i];
            exp_done = (i == 0 && first == 1);
            check($sformatf("%s tick%0d {done,busy,sel,out}", name, i), obs(),
                  {exp_done, 1'b1, sc[1:0], lc[0]});
        end
        wait_tick();
        if (chain_out) check($sformatf("%s end chained", name), obs(), 5'b1_1_00_0);
        else           check($sformatf("%s end idle", name), obs(), 5'b1_0_11_1);
        if (!chain_out) begin
            @(posedge clk);
            #1;
            check($sformatf("%s done width", name), obs(), 5'b0_0_11_1);
        end
    endtask

    initial begin
        string      l1, s1, l2, s2;
        logic [8:0] w1, w2;
        int         g, n, done_cnt;
        bit         prod_done;

        vecs[0] = mk(8, 9'h0A5, 2'b00, 1'b0, "0101001011",   "0111111113");
        vecs[1] = mk(8, 9'h007, 2'b01, 1'b0, "01110000011",  "01111111123");
        vecs[2] = mk(8, 9'h007, 2'b10, 1'b0, "01110000001",  "01111111123");
        vecs[3] = mk(8, 9'h000, 2'b00, 1'b1, "00000000011",  "01111111133");
        vecs[4] = mk(8, 9'h0FF, 2'b11, 1'b0, "0111111111",   "0111111113");
        vecs[5] = mk(8, 9'h001, 2'b01, 1'b1, "010000000111", "011111111233");
        vecs[6] = mk(8, 9'h080, 2'b10, 1'b0, "00000000101",  "01111111123");
        vecs[7] = mk(7, 9'h000, 2'b10, 1'b1, "00000000111",  "01111111233");

        // Clock/reset
        rst_n = 1'b0; tick_en = 1'b0;
        data8 = '0; valid8 = 1'b0; pm8 = 2'b00; s2_8 = 1'b0;
        data7 = '0; valid7 = 1'b0; pm7 = 2'b00; s2_7 = 1'b0;
        #23;
        check("reset dut8 {ready,done,busy,sel,out}", {ready8, done8, busy8, sel8, out8}, 6'b1_0_0_11_1);
        check("reset dut7 {ready,done,busy,sel,out}", {ready7, done7, busy7, sel7, out7}, 6'b1_0_0_11_1);
        @(negedge clk);
        rst_n = 1'b1;
        tick_en = 1'b1;

        // Constant frame table
        for (int v = 0; v < 8; v++) begin
            dut_sel = vecs[v].w;
            set_cfg(vecs[v].w, vecs[v].pm, vecs[v].s2);
            send(vecs[v].w, vecs[v].data);
            check_frame(vecs[v].line, vecs[v].sel, 0, 1'b0, $sformatf("vec%0d", v));
        end

        // Random 7-bit frames on the narrow instance
        dut_sel = 7;
        for (int k = 0; k < 4; k++) begin
            w1 = 9'($urandom_range(0, 127));
            set_cfg(7, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            build_frame(w1, 7, pm7, s2_7, l1, s1);
            send(7, w1);
            check_frame(l1, s1, 0, 1'b0, $sformatf("rand7_%0d", k));
        end
        dut_sel = 8;

        // Back-to-back: second word waits in the holding register, no idle tick between frames
        set_cfg(8, 2'b00, 1'b0);
        tick_en = 1'b0;
        w1 = 9'h03C; w2 = 9'h0C3;
        build_frame(w1, 8, 2'b00, 1'b0, l1, s1);
        build_frame(w2, 8, 2'b00, 1'b0, l2, s2);
        send(8, w1);
        @(negedge clk);
        data8 = w2[7:0];
        valid8 = 1'b1;
        repeat (5) @(negedge clk);
        check("b2b ready low while held", ready8, 1'b0);
        check("b2b frozen idle busy", busy8, 1'b0);
        tick_en = 1'b1;
        g = 0;
        while (!ready8 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("b2b ready rises after load {busy,sel}", {ready8, busy8, sel8}, 4'b1_1_00);
        fork
            begin
                @(posedge clk);
                @(negedge clk);
                valid8 = 1'b0;
            end
            check_frame(l1, s1, 2, 1'b1, "b2b first");
        join
        check_frame(l2, s2, 1, 1'b0, "b2b second");

        // baud_tick held low mid-frame: outputs frozen, handshake still accepts
        w1 = 9'h0B6; w2 = 9'h049;
        build_frame(w1, 8, 2'b00, 1'b0, l1, s1);
        build_frame(w2, 8, 2'b00, 1'b0, l2, s2);
        send(8, w1);
        fork
            check_frame(l1, s1, 0, 1'b1, "freeze first");
            begin
                repeat (4) wait_tick();
                tick_en = 1'b0;
                repeat (12) @(negedge clk);
                check("freeze held data bit2", obs(), {1'b0, 1'b1, 2'b01, w1[2]});
                send(8, w2);
                check("freeze accept while frozen ready", ready8, 1'b0);
                check("freeze still data bit2", obs(), {1'b0, 1'b1, 2'b01, w1[2]});
                tick_en = 1'b1;
            end
        join
        check_frame(l2, s2, 1, 1'b0, "freeze second");

        // parity_mode changed none->even mid-frame applies to the next frame only
        set_cfg(8, 2'b00, 1'b0);
        w1 = 9'h0E1; w2 = 9'h0E1;
        build_frame(w1, 8, 2'b00, 1'b0, l1, s1);
        build_frame(w2, 8, 2'b01, 1'b0, l2, s2);
        send(8, w1);
        fork
            check_frame(l1, s1, 0, 1'b1, "cfg first");
            begin
                repeat (3) wait_tick();
                pm8 = 2'b01;
                send(8, w2);
            end
        join
        check_frame(l2, s2, 1, 1'b0, "cfg second");

        // Asynchronous reset mid-DATA, then a clean frame
        set_cfg(8, 2'b10, 1'b1);
        send(8, 9'h05A);
        repeat (4) wait_tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset {ready,done,busy,sel,out}", {ready8, done8, busy8, sel8, out8}, 6'b1_0_0_11_1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w1 = 9'h0D3;
        build_frame(w1, 8, 2'b10, 1'b1, l1, s1);
        send(8, w1);
        check_frame(l1, s1, 0, 1'b0, "after reset");

        // Randomized bursts against the scoreboard queue
        for (int b = 0; b < 6; b++) begin
            set_cfg(8, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            n = $urandom_range(2, 5);
            prod_done = 1'b0;
            done_cnt = 0;
            fork
                begin
                    for (int k = 0; k < n; k++) begin
                        logic [7:0] lc, sc;
                        repeat ($urandom_range(0, 30)) @(negedge clk);
                        w1 = 9'($urandom_range(0, 255));
                        build_frame(w1, 8, pm8, s2_8, l1, s1);
                        send(8, w1);
                        for (int i = 0; i < l1.len(); i++) begin
                            lc = l1[i];
                            sc = s1[i];
                            exp_q.push_back({sc[1:0], lc[0]});
                        end
                    end
                    prod_done = 1'b1;
                end
                begin
                    logic [2:0] e;
                    g = 0;
                    while (!(prod_done && exp_q.size() == 0 && !busy8) && g < 5000) begin
                        wait_tick();
                        g++;
                        if (done8) done_cnt++;
                        if (busy8) begin
                            if (exp_q.size() == 0) begin
                                fail_now($sformatf("burst%0d busy with no expected field", b));
                            end else begin
                                e = exp_q.pop_front();
                                check($sformatf("burst%0d field {sel,out}", b), {sel8, out8}, e);
                            end
                        end
                    end
                    if (g >= 5000) fail_now($sformatf("burst%0d monitor timeout", b));
                end
            join
            check($sformatf("burst%0d done pulses", b), done_cnt, n);
            check($sformatf("burst%0d leftover fields", b), exp_q.size(), 0);
            exp_q.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
